// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for a word-addressed data memory
module mem_access_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int WORD_AW   = $clog2(MEM_WORDS)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_busy,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_fault,
    output logic        o_mem_writeenable,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data_in,
    input  logic [31:0] i_mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_funct3;
    logic [WORD_AW-1:0]   r_index;
    logic [1:0]           r_lane;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_fault;

    logic                 w_legal;
    logic                 w_misaligned;
    logic                 w_fault;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load_data;
    logic [31:0]          w_merged;
    logic                 w_unused_addr;

    // Bits above the word index are dropped, so the index wraps around memory.
    assign w_unused_addr = ^i_req_addr[31:WORD_AW+2];

    always_comb begin
        w_legal      = i_req_write ? (i_req_funct3 inside {3'b000, 3'b001, 3'b010})
                                   : (i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0])
                    || ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        w_fault      = !w_legal || w_misaligned;
    end

    always_comb begin
        w_byte = i_mem_data_out[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? i_mem_data_out[31:16] : i_mem_data_out[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = i_mem_data_out;
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = 32'b0;
        endcase
    end

    // funct3[0] separates SH (001) from SB (000); SW never takes the RMW path.
    always_comb begin
        w_merged = i_mem_data_out;
        if (r_funct3[0]) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end else begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next            = r_state;
        o_busy            = (r_state != S_IDLE);
        o_resp_valid      = 1'b0;
        o_mem_writeenable = 1'b0;
        o_mem_addr        = 32'b0;
        o_mem_data_in     = 32'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_fault)                     w_next = S_RESP;
                    else if (!i_req_write)           w_next = S_LOAD;
                    else if (i_req_funct3 == 3'b010) w_next = S_WRITE;
                    else                             w_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                o_mem_addr = {{(32-WORD_AW){1'b0}}, r_index};
                w_next     = S_RESP;
            end
            S_WRITE: begin
                o_mem_writeenable = !i_reset;
                o_mem_addr        = {{(32-WORD_AW){1'b0}}, r_index};
                o_mem_data_in     = r_wdata;
                w_next            = S_RESP;
            end
            S_RMW_RD: begin
                o_mem_addr = {{(32-WORD_AW){1'b0}}, r_index};
                w_next     = S_RMW_WR;
            end
            S_RMW_WR: begin
                o_mem_writeenable = !i_reset;
                o_mem_addr        = {{(32-WORD_AW){1'b0}}, r_index};
                o_mem_data_in     = r_wdata;
                w_next            = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Response registers change only on the edge entering S_RESP, so they hold between responses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_funct3 <= 3'b0;
            r_index  <= '0;
            r_lane   <= 2'b0;
            r_wdata  <= 32'b0;
            r_rdata  <= 32'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_funct3 <= i_req_funct3;
                        r_index  <= i_req_addr[WORD_AW+1:2];
                        r_lane   <= i_req_addr[1:0];
                        r_wdata  <= i_req_wdata;
                        if (w_fault) begin
                            r_rdata <= 32'b0;
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_load_data;
                    r_fault <= 1'b0;
                end
                S_RMW_RD: r_wdata <= w_merged;
                S_WRITE, S_RMW_WR: begin
                    r_rdata <= 32'b0;
                    r_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_resp_rdata = r_rdata;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = 10'd0;
    logic [31:0] bd_val = 32'd0;
    int          we_total = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(1024), .WORD_AW(10)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req_valid      (req_valid),
        .i_req_write      (req_write),
        .i_req_funct3     (req_funct3),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_busy           (busy),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_fault          (fault),
        .o_mem_writeenable(mem_we),
        .o_mem_addr       (mem_addr),
        .o_mem_data_in    (mem_data_in),
        .i_mem_data_out   (mem_data_out)
    );

    assign mem_data_out = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (bd_we)       mem[bd_idx] <= bd_val;
        else if (mem_we) mem[mem_addr[9:0]] <= mem_data_in;
        if (mem_we) we_total <= we_total + 1;
    end

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_flt;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_mem(input int i, input logic [31:0] v);
        bd_we = 1'b1; bd_idx = 10'(i); bd_val = v; ref_mem[i] = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issue one request from IDLE and observe it until RESP_VALID (bounded), ending back in IDLE.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic flt,
                          output int wes, output logic [31:0] wa, output int busy_low);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rd = 32'hx; flt = 1'bx; wes = 0; wa = 32'h0; busy_low = 0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin wes++; wa = mem_addr; end
            if (!busy) busy_low++;
            if (resp_valid) begin lat = c; rd = resp_rdata; flt = fault; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Reference behaviour from the byte-addressed ISA rules using plain arithmetic on a word array.
    task automatic ref_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] e_rd, output logic e_flt, output int e_lat, output int e_we);
        int     idx, off, size;
        logic   legal;
        longint word, mask, val;
        idx   = int'((longint'(a) / 4) % 1024);
        off   = int'(longint'(a) % 4);
        legal = w ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        size  = 1 << (f3 % 4);
        e_rd  = 32'h0; e_we = 0; e_flt = 1'b0; e_lat = 1;
        if (!legal || (longint'(a) % size) != 0) begin
            e_flt = 1'b1;
        end else begin
            word = longint'(ref_mem[idx]);
            mask = (64'd1 << (8 * size)) - 1;
            if (!w) begin
                val = (word >> (8 * off)) & mask;
                if (f3 < 4 && size < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
                e_rd  = val[31:0];
                e_lat = 2;
            end else begin
                val = (word & ~(mask << (8 * off))) | ((longint'(d) & mask) << (8 * off));
                ref_mem[idx] = val[31:0];
                e_we  = 1;
                e_lat = (size == 4) ? 2 : 3;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, wes, busy_low, we_before, idx, pulses;
        logic [31:0] rd, wa, e_rd, word2;
        logic        flt, e_flt, w;
        logic [2:0]  f3;
        logic [31:0] a, d;
        int          e_lat, e_we;

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'd8; req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) set_mem(i, $urandom);

        check("reset_busy", 32'(busy), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_we", 32'(mem_we), 32'd0);
        check("reset_rdata", resp_rdata, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_data_in", mem_data_in, 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        set_mem(1, 32'h000000F6);
        vecs[0]  = '{1'b0, 3'b000, 32'd4,  32'h0,        32'hFFFFFFF6, 1'b0, 2, 0, 32'h0};
        vecs[1]  = '{1'b0, 3'b100, 32'd4,  32'h0,        32'h000000F6, 1'b0, 2, 0, 32'h0};
        vecs[2]  = '{1'b1, 3'b010, 32'd8,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 3'b010, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
        vecs[4]  = '{1'b1, 3'b000, 32'd9,  32'h000000AA, 32'h0,        1'b0, 3, 1, 32'hDEADAAEF};
        vecs[5]  = '{1'b1, 3'b001, 32'd10, 32'h00001234, 32'h0,        1'b0, 3, 1, 32'h1234AAEF};
        vecs[6]  = '{1'b0, 3'b001, 32'd10, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'h0};
        vecs[7]  = '{1'b0, 3'b001, 32'd8,  32'h0,        32'hFFFFAAEF, 1'b0, 2, 0, 32'h0};
        vecs[8]  = '{1'b0, 3'b101, 32'd8,  32'h0,        32'h0000AAEF, 1'b0, 2, 0, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'd6,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'd3,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'd8,  32'h55555555, 32'h0,        1'b1, 1, 0, 32'h1234AAEF};
        vecs[13] = '{1'b1, 3'b010, 32'hFFFFF008, 32'h0BADF00D, 32'h0,  1'b0, 2, 1, 32'h0BADF00D};

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, flt, wes, wa, busy_low);
            idx = int'((vecs[i].addr >> 2) & 32'h3FF);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].exp_flt));
            check($sformatf("vec%0d_we_cycles", i), 32'(wes), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_busy_low", i), 32'(busy_low), 32'd0);
            check($sformatf("vec%0d_resp_pulse", i), 32'(resp_valid), 32'd0);
            check($sformatf("vec%0d_rdata_hold", i), resp_rdata, vecs[i].exp_rd);
            if (vecs[i].exp_we != 0)
                check($sformatf("vec%0d_we_addr", i), wa, 32'(idx));
            if (vecs[i].w) begin
                check($sformatf("vec%0d_mem", i), mem[idx], vecs[i].exp_mem);
                if (!vecs[i].exp_flt) ref_mem[idx] = vecs[i].exp_mem;
            end
        end

        // Reset while an SB is in its read phase must abort without touching memory.
        set_mem(1, 32'h11223344);
        we_before = we_total;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'd4; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy_after", 32'(busy), 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid) pulses++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_resp", 32'(pulses), 32'd0);
        check("rst_mid_no_we", 32'(we_total - we_before), 32'd0);
        check("rst_mid_mem", mem[1], ref_mem[1]);
        check("rst_mid_rdata", resp_rdata, 32'd0);

        // REQ_VALID held high: three loads accepted on a 3-cycle cadence.
        word2 = ref_mem[2];
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'd8; req_wdata = 32'd0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_c%0d_resp", c), 32'(resp_valid), 32'((c % 3 == 2) && (c <= 8)));
            check($sformatf("b2b_c%0d_busy", c), 32'(busy), 32'((c % 3 != 0) && (c <= 8)));
            if (resp_valid) begin
                pulses++;
                check($sformatf("b2b_c%0d_rdata", c), resp_rdata, word2);
            end
            if (c == 8) req_valid = 1'b0;
        end
        check("b2b_pulses", 32'(pulses), 32'd3);

        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            d  = $urandom;
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF000);
            idx = int'((a >> 2) & 32'h3FF);
            ref_op(w, f3, a, d, e_rd, e_flt, e_lat, e_we);
            do_req(w, f3, a, d, lat, rd, flt, wes, wa, busy_low);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_rdata", n), rd, e_rd);
            check($sformatf("rnd%0d_fault", n), 32'(flt), 32'(e_flt));
            check($sformatf("rnd%0d_we_cycles", n), 32'(wes), 32'(e_we));
            if (e_we != 0) check($sformatf("rnd%0d_we_addr", n), wa, 32'(idx));
            check($sformatf("rnd%0d_mem", n), mem[idx], ref_mem[idx]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
